// File: rtl/sort_ctrl.sv
// ---------------------------------------------------------------------------
// sort_ctrl
//
// Packet-level controller that sits between a streaming source/sink pair and
// an external sort engine. One packet at a time is captured into a local
// buffer (at most 2**AWIDTH words, any excess is dropped and flagged). The
// engine is told to load and sort the packet. The sorted words the engine
// returns are then replayed on the source side with packet framing.
//
// Ports
//   clk_i, arst_n_i          clock, asynchronous active-low reset
//   snk_data_i               input stream word
//   snk_startofpacket_i      input framing: first word of packet
//   snk_endofpacket_i        input framing: last word of packet
//   snk_valid_i              input word qualifier
//   snk_ready_o              block can accept a word this cycle
//   src_data_o               sorted output word (zero when not valid)
//   src_startofpacket_o      output framing: first sorted word
//   src_endofpacket_o        output framing: last sorted word
//   src_valid_o              output qualifier (no backpressure)
//   eng_wren_o               engine: load the buffered packet
//   eng_sort_op_o            engine: keep sorting
//   eng_output_op_o          engine: present next sorted word
//   eng_clear_op_o           engine: discard state for this packet
//   eng_cntr_o               index of last valid word in the buffer
//   eng_rdaddr_i             engine read address into the buffer
//   eng_data_o               buffer word at eng_rdaddr_i (combinational)
//   eng_sort_done_i          engine has finished sorting
//   eng_data_i               word returned by the engine
//   busy_o                   a packet is in progress
//   trunc_o                  one-cycle pulse when a packet was truncated
// ---------------------------------------------------------------------------
module sort_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  output logic              eng_wren_o,
  output logic              eng_sort_op_o,
  output logic              eng_output_op_o,
  output logic              eng_clear_op_o,
  output logic [AWIDTH-1:0] eng_cntr_o,
  input  logic [AWIDTH-1:0] eng_rdaddr_i,
  output logic [DWIDTH-1:0] eng_data_o,
  input  logic              eng_sort_done_i,
  input  logic [DWIDTH-1:0] eng_data_i,
  output logic              busy_o,
  output logic              trunc_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0]   LP_DEPTH   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   LP_CNT_ONE = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] LP_IDX_ONE = AWIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_LOAD,
    S_SORT,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t r_state;

  logic [DWIDTH-1:0] r_buf [DEPTH];

  logic [AWIDTH:0]   r_cnt;
  logic [AWIDTH-1:0] r_engCntr;
  logic [AWIDTH-1:0] r_drainIdx;
  logic              r_truncFlag;
  logic              r_ready;
  logic              r_busy;
  logic              r_trunc;
  logic              r_wren;
  logic              r_sortOp;
  logic              r_outputOp;
  logic              r_clearOp;
  logic              r_srcValid;
  logic              r_srcSop;
  logic              r_srcEop;

  logic              w_accept;
  logic              w_lastBeat;
  logic              w_bufWe;
  logic [AWIDTH-1:0] w_bufAddr;
  logic [AWIDTH:0]   w_cntNext;
  logic [AWIDTH-1:0] w_engCntrNext;
  logic              w_overflow;

  assign w_accept = snk_valid_i & r_ready;

  // Receive-path decode: where an accepted word lands in the buffer and what
  // the word count becomes. A start-of-packet always restarts at slot 0, so a
  // packet interrupted by a fresh sop simply forgets its earlier words. Once
  // the buffer is full, further words are swallowed and only flagged.
  always_comb begin
    w_bufWe    = 1'b0;
    w_bufAddr  = '0;
    w_cntNext  = r_cnt;
    w_overflow = 1'b0;
    if (w_accept && (r_state == S_IDLE || r_state == S_RECV)) begin
      if (snk_startofpacket_i) begin
        w_bufWe   = 1'b1;
        w_bufAddr = '0;
        w_cntNext = LP_CNT_ONE;
      end else if (r_state == S_RECV) begin
        if (r_cnt < LP_DEPTH) begin
          w_bufWe   = 1'b1;
          w_bufAddr = r_cnt[AWIDTH-1:0];
          w_cntNext = r_cnt + LP_CNT_ONE;
        end else begin
          w_overflow = 1'b1;
        end
      end
    end
  end

  // A full buffer has a count of 2**AWIDTH, whose low bits are zero; the
  // wrap of the narrow subtraction gives the correct last index for it too.
  assign w_engCntrNext = w_cntNext[AWIDTH-1:0] - LP_IDX_ONE;

  // End of packet is only honoured once a packet has been opened by a sop
  // (in IDLE, the closing word must itself carry the sop).
  assign w_lastBeat = w_accept & snk_endofpacket_i &
                      ((r_state == S_RECV) ||
                       (r_state == S_IDLE && snk_startofpacket_i));

  // Packet buffer. It has no reset: its contents only matter once they are
  // written, and the engine only reads indices below the current count.
  always_ff @(posedge clk_i) begin
    if (w_bufWe) begin
      r_buf[w_bufAddr] <= snk_data_i;
    end
  end

  assign eng_data_o = r_buf[eng_rdaddr_i];

  // Control FSM. Every output is a register that is loaded with its value
  // for the state being entered, so nothing on the ports glitches. The
  // source-side framing is the output-op pulse train delayed by one cycle,
  // which lines it up with the word the engine returns for each pulse.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_engCntr   <= '0;
      r_drainIdx  <= '0;
      r_truncFlag <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_trunc     <= 1'b0;
      r_wren      <= 1'b0;
      r_sortOp    <= 1'b0;
      r_outputOp  <= 1'b0;
      r_clearOp   <= 1'b0;
      r_srcValid  <= 1'b0;
      r_srcSop    <= 1'b0;
      r_srcEop    <= 1'b0;
    end else begin
      r_wren     <= 1'b0;
      r_trunc    <= 1'b0;
      r_clearOp  <= 1'b0;
      r_srcValid <= r_outputOp;
      r_srcSop   <= r_outputOp && (r_drainIdx == '0);
      r_srcEop   <= r_outputOp && (r_drainIdx == r_engCntr);

      case (r_state)
        S_IDLE, S_RECV: begin
          r_cnt   <= w_cntNext;
          r_ready <= 1'b1;
          if (w_accept) begin
            if (snk_startofpacket_i) begin
              r_truncFlag <= 1'b0;
            end else if (w_overflow) begin
              r_truncFlag <= 1'b1;
            end
          end
          if (w_lastBeat) begin
            r_state   <= S_LOAD;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_wren    <= 1'b1;
            r_engCntr <= w_engCntrNext;
            r_trunc   <= !snk_startofpacket_i && (r_truncFlag || w_overflow);
          end else if (w_accept && snk_startofpacket_i) begin
            r_state <= S_RECV;
            r_busy  <= 1'b1;
          end
        end

        S_LOAD: begin
          r_state  <= S_SORT;
          r_sortOp <= 1'b1;
        end

        S_SORT: begin
          if (eng_sort_done_i) begin
            r_state    <= S_DRAIN;
            r_sortOp   <= 1'b0;
            r_outputOp <= 1'b1;
            r_drainIdx <= '0;
          end
        end

        // One output op per buffered word, then one idle drain cycle while
        // the final word is on the source port, then the clear.
        S_DRAIN: begin
          if (r_outputOp) begin
            if (r_drainIdx == r_engCntr) begin
              r_outputOp <= 1'b0;
            end else begin
              r_drainIdx <= r_drainIdx + LP_IDX_ONE;
            end
          end else begin
            r_state   <= S_CLEAR;
            r_clearOp <= 1'b1;
          end
        end

        S_CLEAR: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_engCntr   <= '0;
          r_drainIdx  <= '0;
          r_truncFlag <= 1'b0;
          r_busy      <= 1'b0;
          r_ready     <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign snk_ready_o         = r_ready;
  assign busy_o              = r_busy;
  assign trunc_o             = r_trunc;
  assign eng_wren_o          = r_wren;
  assign eng_sort_op_o       = r_sortOp;
  assign eng_output_op_o     = r_outputOp;
  assign eng_clear_op_o      = r_clearOp;
  assign eng_cntr_o          = r_engCntr;
  assign src_valid_o         = r_srcValid;
  assign src_startofpacket_o = r_srcSop;
  assign src_endofpacket_o   = r_srcEop;
  assign src_data_o          = r_srcValid ? eng_data_i : '0;

endmodule

// File: tb/tb_sort_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sort_ctrl
//
// Drives packets into sort_ctrl, plays the part of the sort engine, and
// checks the sorted output stream against a packet-level reference model.
// The model keeps the words of the open packet. From those words it derives
// the expected sorted packet, the last-word index and the truncation flag.
// ---------------------------------------------------------------------------
module tb_sort_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [DW-1:0] snk_data_i;
  logic          snk_sop_i;
  logic          snk_eop_i;
  logic          snk_valid_i;
  logic          snk_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_startofpacket_o;
  logic          src_endofpacket_o;
  logic          src_valid_o;
  logic          eng_wren_o;
  logic          eng_sort_op_o;
  logic          eng_output_op_o;
  logic          eng_clear_op_o;
  logic [AW-1:0] eng_cntr_o;
  logic [AW-1:0] eng_rdaddr_i;
  logic [DW-1:0] eng_data_o;
  logic          eng_sort_done_i;
  logic [DW-1:0] eng_data_i;
  logic          busy_o;
  logic          trunc_o;

  always #5 clk = ~clk;

  sort_ctrl #(
    .DWIDTH(DW),
    .AWIDTH(AW)
  ) dut (
    .clk_i              (clk),
    .arst_n_i           (arst_n),
    .snk_data_i         (snk_data_i),
    .snk_startofpacket_i(snk_sop_i),
    .snk_endofpacket_i  (snk_eop_i),
    .snk_valid_i        (snk_valid_i),
    .snk_ready_o        (snk_ready_o),
    .src_data_o         (src_data_o),
    .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o  (src_endofpacket_o),
    .src_valid_o        (src_valid_o),
    .eng_wren_o         (eng_wren_o),
    .eng_sort_op_o      (eng_sort_op_o),
    .eng_output_op_o    (eng_output_op_o),
    .eng_clear_op_o     (eng_clear_op_o),
    .eng_cntr_o         (eng_cntr_o),
    .eng_rdaddr_i       (eng_rdaddr_i),
    .eng_data_o         (eng_data_o),
    .eng_sort_done_i    (eng_sort_done_i),
    .eng_data_i         (eng_data_i),
    .busy_o             (busy_o),
    .trunc_o            (trunc_o)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: the open packet and the one expected on output.
  logic [DW-1:0] curWords[$];
  int            curTotal = 0;
  bit            inPkt    = 1'b0;
  bit            expValid = 1'b0;
  int            expLen   = 0;
  bit            expTrunc = 1'b0;
  logic [DW-1:0] expWords [DEPTH];

  // Per-packet observations gathered by the monitor.
  int outIdx  = 0;
  int opCnt   = 0;
  int wrenCnt = 0;
  int truncCnt = 0;
  int lat     = -1;

  // Engine model state.
  logic [DW-1:0] engMem [DEPTH];
  int engLen   = 0;
  int engRd    = 0;
  int engOut   = 0;
  int engDelay = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Packet-level view of the sink side: a sop opens a new packet and drops
  // whatever was open, a word outside a packet is ignored, only the first
  // DEPTH words of a packet are kept, and eop closes it. The engine
  // returns the kept words in ascending order.
  task automatic modelAccept(input logic [DW-1:0] d, input bit s, input bit e);
    logic [DW-1:0] tmp;
    if (s) begin
      curWords.delete();
      curWords.push_back(d);
      curTotal = 1;
      inPkt    = 1'b1;
    end else if (inPkt) begin
      curTotal++;
      if (curWords.size() < DEPTH) curWords.push_back(d);
    end
    if (e && inPkt) begin
      expLen   = curWords.size();
      expTrunc = (curTotal > DEPTH);
      for (int i = 0; i < expLen; i++) expWords[i] = curWords[i];
      for (int i = 0; i < expLen; i++) begin
        for (int j = 0; j < expLen - 1 - i; j++) begin
          if (expWords[j] > expWords[j+1]) begin
            tmp           = expWords[j];
            expWords[j]   = expWords[j+1];
            expWords[j+1] = tmp;
          end
        end
      end
      outIdx   = 0;
      opCnt    = 0;
      wrenCnt  = 0;
      truncCnt = 0;
      expValid = 1'b1;
      inPkt    = 1'b0;
    end
  endtask

  // Present one word, hold it until the block takes it, then let the model
  // know it was accepted.
  task automatic applyStimulus(input logic [DW-1:0] d, input bit s, input bit e);
    int  n   = 0;
    bit  acc = 1'b0;
    int  gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    snk_data_i  = d;
    snk_sop_i   = s;
    snk_eop_i   = e;
    snk_valid_i = 1'b1;
    while (!acc && n < 200) begin
      @(posedge clk);
      acc = snk_ready_o;
      n++;
    end
    if (acc) modelAccept(d, s, e);
    else checkOutput("sinkHandshake", {31'd0, acc}, 32'd1);
    #1;
    snk_valid_i = 1'b0;
    snk_sop_i   = 1'b0;
    snk_eop_i   = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (expValid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("packetComplete", {31'd0, expValid}, 32'd0);
  endtask

  // Sort engine: loads its length on wren, reads the buffer one word per
  // sort cycle, takes a few extra cycles, pulses done, and returns one
  // sorted word in the cycle after each output op.
  initial begin
    logic          sWr, sSort, sOut;
    logic [AW-1:0] sCntr;
    logic [DW-1:0] sWord;
    logic [DW-1:0] tmp;
    eng_sort_done_i = 1'b0;
    eng_data_i      = '0;
    eng_rdaddr_i    = '0;
    forever begin
      @(posedge clk);
      sWr   = eng_wren_o;
      sSort = eng_sort_op_o;
      sOut  = eng_output_op_o;
      sCntr = eng_cntr_o;
      sWord = eng_data_o;
      #1;
      if (!arst_n) begin
        engLen = 0; engRd = 0; engOut = 0;
        eng_sort_done_i = 1'b0;
        eng_rdaddr_i    = '0;
        eng_data_i      = '0;
      end else begin
        if (sWr) begin
          engLen   = int'(sCntr) + 1;
          engRd    = 0;
          engOut   = 0;
          engDelay = $urandom_range(0, 3);
          eng_rdaddr_i = '0;
        end else if (sSort && !eng_sort_done_i) begin
          if (engRd < engLen) begin
            engMem[engRd] = sWord;
            engRd++;
            if (engRd < engLen) eng_rdaddr_i = AW'(engRd);
          end else if (engDelay > 0) begin
            engDelay--;
          end else begin
            for (int i = 0; i < engLen; i++) begin
              for (int j = 0; j < engLen - 1 - i; j++) begin
                if (engMem[j] > engMem[j+1]) begin
                  tmp         = engMem[j];
                  engMem[j]   = engMem[j+1];
                  engMem[j+1] = tmp;
                end
              end
            end
            eng_sort_done_i = 1'b1;
          end
        end else begin
          eng_sort_done_i = 1'b0;
        end
        if (sOut) begin
          eng_data_i = (engOut < DEPTH) ? engMem[engOut] : '0;
          engOut++;
        end
      end
    end
  end

  // Output monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (arst_n) begin
      if (eng_sort_done_i) lat = 0;
      else if (lat >= 0) lat++;

      if (eng_wren_o) begin
        checkOutput("wrenPending", {31'd0, expValid}, 32'd1);
        if (expValid) begin
          wrenCnt++;
          checkOutput("engCntr", {28'd0, eng_cntr_o}, expLen - 1);
          checkOutput("busyLoad", {31'd0, busy_o}, 32'd1);
        end
      end

      if (trunc_o) truncCnt++;

      if (eng_output_op_o) begin
        opCnt++;
        checkOutput("sortOpInDrain", {31'd0, eng_sort_op_o}, 32'd0);
      end

      if (src_valid_o) begin
        checkOutput("srcPending", {31'd0, expValid}, 32'd1);
        if (expValid) begin
          if (outIdx == 0) checkOutput("firstWordLatency", lat, 32'd2);
          if (outIdx < expLen) checkOutput("srcData", {24'd0, src_data_o}, {24'd0, expWords[outIdx]});
          else checkOutput("srcWordCount", outIdx, expLen - 1);
          checkOutput("srcSop", {31'd0, src_startofpacket_o}, {31'd0, outIdx == 0});
          checkOutput("srcEop", {31'd0, src_endofpacket_o}, {31'd0, outIdx == expLen - 1});
          outIdx++;
        end
      end

      if (eng_clear_op_o) begin
        checkOutput("clearPending", {31'd0, expValid}, 32'd1);
        if (expValid) begin
          checkOutput("wordsOut", outIdx, expLen);
          checkOutput("outputOps", opCnt, expLen);
          checkOutput("wrenPulses", wrenCnt, 32'd1);
          checkOutput("truncPulses", truncCnt, {31'd0, expTrunc});
          checkOutput("busyClear", {31'd0, busy_o}, 32'd1);
          expValid = 1'b0;
          lat      = -1;
        end
      end
    end
  end

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_ready"},  {31'd0, snk_ready_o}, 32'd0);
    checkOutput({tag, "_busy"},   {31'd0, busy_o}, 32'd0);
    checkOutput({tag, "_valid"},  {31'd0, src_valid_o}, 32'd0);
    checkOutput({tag, "_sop"},    {31'd0, src_startofpacket_o}, 32'd0);
    checkOutput({tag, "_eop"},    {31'd0, src_endofpacket_o}, 32'd0);
    checkOutput({tag, "_data"},   {24'd0, src_data_o}, 32'd0);
    checkOutput({tag, "_wren"},   {31'd0, eng_wren_o}, 32'd0);
    checkOutput({tag, "_sortOp"}, {31'd0, eng_sort_op_o}, 32'd0);
    checkOutput({tag, "_outOp"},  {31'd0, eng_output_op_o}, 32'd0);
    checkOutput({tag, "_clrOp"},  {31'd0, eng_clear_op_o}, 32'd0);
    checkOutput({tag, "_cntr"},   {28'd0, eng_cntr_o}, 32'd0);
    checkOutput({tag, "_trunc"},  {31'd0, trunc_o}, 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", {31'd0, snk_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("readyAfterEdge", {31'd0, snk_ready_o}, 32'd1);
  endtask

  initial begin
    int            n;
    int            len;
    int            restartPos;
    logic [DW-1:0] d;

    arst_n      = 1'b0;
    snk_data_i  = '0;
    snk_sop_i   = 1'b0;
    snk_eop_i   = 1'b0;
    snk_valid_i = 1'b0;

    repeat (2) @(negedge clk);
    checkAllIdle("reset");
    releaseReset();

    // Packet 5,3,9,1.
    applyStimulus(8'd5, 1'b1, 1'b0);
    applyStimulus(8'd3, 1'b0, 1'b0);
    applyStimulus(8'd9, 1'b0, 1'b0);
    applyStimulus(8'd1, 1'b0, 1'b1);
    waitDone(500);

    // Single word packet.
    applyStimulus(8'h7F, 1'b1, 1'b1);
    waitDone(500);

    // Oversized packet: 20 words into a 16-word buffer.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), i == 0, i == 19);
    end
    waitDone(500);

    // Restart mid-packet: A,B then sop C, D, eop E.
    applyStimulus(8'hA0, 1'b1, 1'b0);
    applyStimulus(8'hB0, 1'b0, 1'b0);
    applyStimulus(8'h0C, 1'b1, 1'b0);
    applyStimulus(8'h0D, 1'b0, 1'b0);
    applyStimulus(8'h0E, 1'b0, 1'b1);
    waitDone(500);

    // Stray word with no sop while idle is dropped.
    applyStimulus(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("strayBusy", {31'd0, busy_o}, 32'd0);
      checkOutput("strayCntr", {28'd0, eng_cntr_o}, 32'd0);
      checkOutput("strayReady", {31'd0, snk_ready_o}, 32'd1);
    end

    // Reset while the engine is sorting.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), i == 0, i == 7);
    end
    n = 0;
    while (!eng_sort_op_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachSort", {31'd0, eng_sort_op_o}, 32'd1);
    checkOutput("busySort", {31'd0, busy_o}, 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    checkAllIdle("midReset");
    expValid = 1'b0;
    inPkt    = 1'b0;
    lat      = -1;
    repeat (2) @(negedge clk);
    releaseReset();
    repeat (30) @(negedge clk);
    applyStimulus(8'h42, 1'b1, 1'b0);
    applyStimulus(8'h24, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b1);
    waitDone(500);

    // Randomized packets, some with strays, restarts and truncation.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 5) == 0) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      len        = $urandom_range(1, 20);
      restartPos = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len) : 0;
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom_range(0, 255));
        applyStimulus(d, (i == 0) || (restartPos != 0 && i == restartPos - 1), i == len - 1);
      end
      waitDone(1000);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
